if_fetch_stage: RTL

- Instruction fetch stage of the pipelined ARMv8 core.
- Owns the PC register and drives a variable-latency instruction memory request/ready interface.
- Feeds the IF/ID pipeline register: current PC, PC+4 link value, the fetched instruction and that register's write enable.
- Accepts stall back-pressure from the hazard unit and redirects (taken branch / exception) from EX/MEM.

---
 rtl/if_fetch_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, issues variable-latency imem requests, feeds IF/ID.
// Latency: zero-wait memory gives one instruction per cycle; the output is combinational from imem_rdata.
// Backpressure: stall_in parks the fetched word in a holding register; redirects beat stalls. Optional IFETCH_PERF_EN adds counters.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter logic [31:0] BUBBLE_INSN = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_wren,
    output logic        fetch_valid,
    output logic [63:0] PC_out,
    output logic [63:0] PC_branch_link,
    output logic [31:0] instruction
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_memwait
`endif
);

    typedef enum logic [1:0] {REQ, HOLD, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [63:0] pend_pc, pend_nxt;
    logic [31:0] hold_buf, buf_nxt;
    logic [63:0] redir_pc;

    assign redir_pc   = redirect_pc & ~64'd3;
    assign imem_addr  = pc;
    assign if_id_wren = !reset && (!stall_in || redirect_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= REQ;
            pc       <= RESET_PC;
            pend_pc  <= '0;
            hold_buf <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            pend_pc  <= pend_nxt;
            hold_buf <= buf_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pend_nxt    = pend_pc;
        buf_nxt     = hold_buf;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        instruction = BUBBLE_INSN;
        PC_out      = '0;
        case (state)
            REQ: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    // An outstanding request keeps its address; the target waits in pend_pc.
                    if (imem_ready) begin
                        pc_nxt = redir_pc;
                    end else begin
                        pend_nxt  = redir_pc;
                        state_nxt = FLUSH;
                    end
                end else if (imem_ready) begin
                    fetch_valid = 1'b1;
                    instruction = imem_rdata;
                    PC_out      = pc;
                    if (stall_in) begin
                        buf_nxt   = imem_rdata;
                        state_nxt = HOLD;
                    end else begin
                        pc_nxt = pc + 64'd4;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redir_pc;
                    state_nxt = REQ;
                end else begin
                    fetch_valid = 1'b1;
                    instruction = hold_buf;
                    PC_out      = pc;
                    if (!stall_in) begin
                        pc_nxt    = pc + 64'd4;
                        state_nxt = REQ;
                    end
                end
            end
            FLUSH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    pc_nxt    = redirect_valid ? redir_pc : pend_pc;
                    state_nxt = REQ;
                end else if (redirect_valid) begin
                    pend_nxt = redir_pc;
                end
            end
            default: state_nxt = REQ;
        endcase
        if (reset) begin
            imem_req    = 1'b0;
            fetch_valid = 1'b0;
            instruction = BUBBLE_INSN;
            PC_out      = '0;
        end
    end

    assign PC_branch_link = fetch_valid ? PC_out + 64'd4 : 64'd0;

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_memwait <= '0;
        end else begin
            if (fetch_valid && !stall_in && !redirect_valid && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (fetch_valid && stall_in && !redirect_valid && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
            if (imem_req && !imem_ready && perf_memwait != '1)
                perf_memwait <= perf_memwait + 32'd1;
        end
    end
`endif

endmodule
